// File: rtl/ble_block_segmenter_param.sv
// Buffers one frame of serial payload bits, then replays it as framed blocks of a run-time size.
// Latency: frame_done at T -> n_blocks at T+1, first read at T+1, first data_out at T+2.
// Backpressure: enable=0 holds the read pointer (gap counting continues); input is not backpressured.
module ble_block_segmenter_param #(
  parameter int ADDR_W = 14,
  parameter int BLK_W  = 5,
  parameter int GAP_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_in,
  input  logic              valid_in,
  input  logic              frame_done,
  input  logic [BLK_W-1:0]  block_size,
  input  logic [GAP_W-1:0]  gap_cycles,
  input  logic              pad_en,
  input  logic              enable,
  output logic              data_out,
  output logic              valid_out,
  output logic              sob,
  output logic              eob,
  output logic [ADDR_W:0]   n_blocks,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [BLK_W-1:0]  BLK_ONE  = {{(BLK_W-1){1'b0}}, 1'b1};
  localparam logic [GAP_W-1:0]  GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READ, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [BLK_W-1:0]  bs_q, bs_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              pad_q, pad_d;
  logic [ADDR_W:0]   bit_cnt_q, bit_cnt_d;
  logic [BLK_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [ADDR_W:0]   full_blk_q, full_blk_d;
  logic [BLK_W-1:0]  rem_q, rem_d;
  logic [ADDR_W:0]   n_blocks_q, n_blocks_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [BLK_W-1:0]  in_blk_q, in_blk_d;
  logic [ADDR_W:0]   blk_idx_q, blk_idx_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic              wr_en;
  logic              rd_vld, rd_pad, rd_sob, rd_eob;
  logic              data_out_q, valid_out_q, sob_q, eob_q;

  logic              mem_q [DEPTH];

  // Block bookkeeping for the block currently being replayed.
  logic [BLK_W-1:0]  fill_plus;
  logic              blk_hit;
  logic              last_blk;
  logic              short_last;
  logic [BLK_W-1:0]  blk_len;
  logic              pad_slot;
  logic              blk_end;

  assign fill_plus  = fill_cnt_q + BLK_ONE;
  assign blk_hit    = (fill_plus == bs_q);
  assign last_blk   = ((blk_idx_q + CNT_ONE) == n_blocks_q);
  assign short_last = last_blk && (rem_q != '0);
  assign blk_len    = (short_last && !pad_q) ? rem_q : bs_q;
  assign pad_slot   = short_last && (in_blk_q >= rem_q);
  assign blk_end    = (in_blk_q == (blk_len - BLK_ONE));

  // Next-state logic: frame capture, block counting, and block replay sequencing.
  always_comb begin
    state_d    = state_q;
    bs_d       = bs_q;
    gap_d      = gap_q;
    pad_d      = pad_q;
    bit_cnt_d  = bit_cnt_q;
    fill_cnt_d = fill_cnt_q;
    full_blk_d = full_blk_q;
    rem_d      = rem_q;
    n_blocks_d = n_blocks_q;
    rd_ptr_d   = rd_ptr_q;
    in_blk_d   = in_blk_q;
    blk_idx_d  = blk_idx_q;
    gap_cnt_d  = gap_cnt_q;
    err_d      = err_q;
    done_d     = 1'b0;
    wr_en      = 1'b0;
    rd_vld     = 1'b0;
    rd_pad     = 1'b0;
    rd_sob     = 1'b0;
    rd_eob     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          // Settings are frozen for the whole frame at its first bit.
          bs_d       = block_size;
          gap_d      = gap_cycles;
          pad_d      = pad_en;
          err_d      = 1'b0;
          wr_en      = 1'b1;
          bit_cnt_d  = CNT_ONE;
          fill_cnt_d = (block_size == BLK_ONE) ? '0 : BLK_ONE;
          full_blk_d = (block_size == BLK_ONE) ? CNT_ONE : '0;
          state_d    = S_LOAD;
        end else if (frame_done) begin
          done_d     = 1'b1;
          n_blocks_d = '0;
        end
      end

      S_LOAD: begin
        if (valid_in) begin
          if (bit_cnt_q == FULL_CNT) begin
            err_d = 1'b1;
          end else begin
            wr_en     = 1'b1;
            bit_cnt_d = bit_cnt_q + CNT_ONE;
            if (blk_hit) begin
              fill_cnt_d = '0;
              full_blk_d = full_blk_q + CNT_ONE;
            end else begin
              fill_cnt_d = fill_plus;
            end
          end
        end
        // Closing uses the counts including a bit written in the same cycle.
        if (frame_done) begin
          if (bs_q == '0) begin
            err_d      = 1'b1;
            done_d     = 1'b1;
            n_blocks_d = '0;
            state_d    = S_IDLE;
          end else begin
            n_blocks_d = full_blk_d + {{ADDR_W{1'b0}}, (fill_cnt_d != '0)};
            rem_d      = fill_cnt_d;
            rd_ptr_d   = '0;
            in_blk_d   = '0;
            blk_idx_d  = '0;
            state_d    = S_READ;
          end
          bit_cnt_d  = '0;
          fill_cnt_d = '0;
          full_blk_d = '0;
        end
      end

      S_READ: begin
        if (valid_in) err_d = 1'b1;
        if (blk_idx_q == n_blocks_q) begin
          // Final bit left the output register last cycle.
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (enable) begin
          rd_vld = 1'b1;
          rd_pad = pad_slot;
          rd_sob = (in_blk_q == '0);
          rd_eob = blk_end;
          if (!pad_slot) rd_ptr_d = rd_ptr_q + PTR_ONE;
          if (blk_end) begin
            in_blk_d  = '0;
            blk_idx_d = blk_idx_q + CNT_ONE;
            if ((gap_q != '0) && !last_blk) begin
              gap_cnt_d = '0;
              state_d   = S_GAP;
            end
          end else begin
            in_blk_d = in_blk_q + BLK_ONE;
          end
        end
      end

      S_GAP: begin
        if (valid_in) err_d = 1'b1;
        gap_cnt_d = gap_cnt_q + GAP_ONE;
        if (gap_cnt_q == (gap_q - GAP_ONE)) state_d = S_READ;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bs_q       <= '0;
      gap_q      <= '0;
      pad_q      <= 1'b0;
      bit_cnt_q  <= '0;
      fill_cnt_q <= '0;
      full_blk_q <= '0;
      rem_q      <= '0;
      n_blocks_q <= '0;
      rd_ptr_q   <= '0;
      in_blk_q   <= '0;
      blk_idx_q  <= '0;
      gap_cnt_q  <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bs_q       <= bs_d;
      gap_q      <= gap_d;
      pad_q      <= pad_d;
      bit_cnt_q  <= bit_cnt_d;
      fill_cnt_q <= fill_cnt_d;
      full_blk_q <= full_blk_d;
      rem_q      <= rem_d;
      n_blocks_q <= n_blocks_d;
      rd_ptr_q   <= rd_ptr_d;
      in_blk_q   <= in_blk_d;
      blk_idx_q  <= blk_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  // Frame buffer write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[bit_cnt_q[ADDR_W-1:0]] <= data_in;
  end

  // Registered output stage: buffer read (or zero pad) lands one cycle after issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q  <= 1'b0;
      valid_out_q <= 1'b0;
      sob_q       <= 1'b0;
      eob_q       <= 1'b0;
    end else begin
      data_out_q  <= rd_vld && !rd_pad && mem_q[rd_ptr_q];
      valid_out_q <= rd_vld;
      sob_q       <= rd_sob;
      eob_q       <= rd_eob;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign sob       = sob_q;
  assign eob       = eob_q;
  assign n_blocks  = n_blocks_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ble_block_segmenter_param.sv
// Randomised scoreboard bench for ble_block_segmenter_param, with a small-buffer instance for overflow.
// Expected blocks come from a frame-level model; a negedge monitor pops and compares each output bit.
// Stalls are injected by dropping enable after a chosen output bit.
module tb_ble_block_segmenter_param;

  logic       clk;
  logic       reset;
  logic       data_in, valid_in, frame_done, pad_en, enable;
  logic [4:0] block_size;
  logic [2:0] gap_cycles;

  logic        data_out, valid_out, sob, eob, busy, done, err;
  logic [14:0] n_blocks;
  logic        data_out_s, valid_out_s, sob_s, eob_s, busy_s, done_s, err_s;
  logic [4:0]  n_blocks_s;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [2:0] exp_q[$];
  int         vo_cyc[$];
  logic       small_q[$];
  int         small_done = 0;
  logic       bits_a [64];

  ble_block_segmenter_param dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .frame_done(frame_done),
    .block_size(block_size), .gap_cycles(gap_cycles), .pad_en(pad_en), .enable(enable),
    .data_out(data_out), .valid_out(valid_out), .sob(sob), .eob(eob), .n_blocks(n_blocks),
    .busy(busy), .done(done), .err(err)
  );

  ble_block_segmenter_param #(.ADDR_W(4), .BLK_W(5), .GAP_W(3)) dut_s (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .frame_done(frame_done),
    .block_size(block_size), .gap_cycles(gap_cycles), .pad_en(pad_en), .enable(enable),
    .data_out(data_out_s), .valid_out(valid_out_s), .sob(sob_s), .eob(eob_s), .n_blocks(n_blocks_s),
    .busy(busy_s), .done(done_s), .err(err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every presented output bit must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (valid_out) begin
        vo_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL out_extra cyc=%0d got={d,sob,eob}=%b required=no output", cyc, {data_out, sob, eob});
        end else begin
          logic [2:0] e;
          e = exp_q.pop_front();
          if ({data_out, sob, eob} !== e) begin
            failures++;
            $display("FAIL out_bit cyc=%0d got={d,sob,eob}=%b required=%b", cyc, {data_out, sob, eob}, e);
          end
        end
      end
      if (valid_out_s) small_q.push_back(data_out_s);
      if (done_s) small_done++;
    end
  end

  task automatic chk(input string nm, input longint got, input longint req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", nm, got, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Frame-level model: split n bits into blocks of bs, pad or shorten the tail.
  task automatic push_model(input int n, input int bs, input bit pd, output int nblk, output int nout);
    int len;
    int idx;
    nblk = (bs == 0) ? 0 : (n + bs - 1) / bs;
    nout = 0;
    for (int b = 0; b < nblk; b++) begin
      len = (b == nblk - 1 && (n % bs) != 0 && !pd) ? (n % bs) : bs;
      for (int i = 0; i < len; i++) begin
        idx = b * bs + i;
        exp_q.push_back({(idx < n) ? bits_a[idx] : 1'b0, i == 0, i == len - 1});
        nout++;
      end
    end
  endtask

  task automatic load_frame(input int n, input int bs, input int gp, input bit pd, output int fd);
    block_size = 5'(bs);
    gap_cycles = 3'(gp);
    pad_en     = pd;
    for (int i = 0; i < n; i++) begin
      data_in  = bits_a[i];
      valid_in = 1'b1;
      tick();
    end
    valid_in   = 1'b0;
    data_in    = 1'b0;
    frame_done = 1'b1;
    fd = cyc;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic run_frame(input int n, input int bs, input int gp, input bit pd, input int stall_after);
    int nblk, nout, fd, seen, stall_left, dc, exp_done;
    bit got;
    vo_cyc.delete();
    push_model(n, bs, pd, nblk, nout);
    load_frame(n, bs, gp, pd, fd);
    chk("n_blocks", n_blocks, nblk);
    seen = 0; stall_left = 0; got = 0; dc = -1;
    for (int k = 0; k < 3000 && !got; k++) begin
      if (done) begin
        got = 1;
        dc = cyc;
        chk("busy_at_done", busy, 0);
      end else begin
        if (stall_left > 0) begin
          enable = 1'b0;
          stall_left--;
        end else begin
          enable = 1'b1;
        end
        if (valid_out) begin
          seen++;
          if (stall_after >= 0 && seen == stall_after + 1) stall_left = 3;
        end
        tick();
      end
    end
    enable = 1'b1;
    if (!got) begin
      failures++;
      checks++;
      $display("FAIL done_timeout got=no done required=done pulse");
    end
    exp_done = (nout == 0) ? fd + 1 : fd + 2 + nout + (nblk - 1) * gp + ((stall_after >= 0) ? 3 : 0);
    chk("done_cycle", dc, exp_done);
    chk("out_count", vo_cyc.size(), nout);
    chk("exp_drained", exp_q.size(), 0);
    if (nout > 0) chk("first_valid_cycle", vo_cyc[0], fd + 2);
    tick();
    chk("done_one_cycle", done, 0);
    exp_q.delete();
  endtask

  initial begin : timeout
    #2000000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [39:0] pat;
    int fd, nb, no, n, bs, gp, mism;
    bit got;
    reset = 1'b1; data_in = 0; valid_in = 0; frame_done = 0; pad_en = 0; enable = 1;
    block_size = 0; gap_cycles = 0;
    tick(); tick();
    chk("reset_outputs", {data_out, valid_out, sob, eob, n_blocks, busy, done, err}, 0);
    reset = 1'b0;
    tick();

    // Fixed pattern, 4 full blocks, contiguous.
    pat = 40'h5A5A5A5A5A;
    for (int i = 0; i < 40; i++) bits_a[i] = pat[i];
    run_frame(40, 10, 0, 1'b1, -1);
    chk("t1_contiguous", vo_cyc[39] - vo_cyc[0], 39);
    chk("t1_err", err, 0);

    // Partial last block, padded and short.
    for (int i = 0; i < 64; i++) bits_a[i] = 1'($urandom);
    run_frame(37, 10, 0, 1'b1, -1);
    run_frame(37, 10, 0, 1'b0, -1);

    // Stall of three cycles after output bit 5.
    for (int i = 0; i < 64; i++) bits_a[i] = 1'($urandom);
    run_frame(16, 8, 0, 1'b1, 5);
    chk("t3_stall_gap", vo_cyc[7] - vo_cyc[6], 4);

    // Inter-block gaps.
    run_frame(12, 4, 3, 1'b1, -1);
    chk("t4_span", vo_cyc[11] - vo_cyc[0], 17);
    chk("t4_gap", vo_cyc[4] - vo_cyc[3], 4);

    // Zero block size: error, no output.
    run_frame(5, 0, 0, 1'b1, -1);
    chk("bs0_err", err, 1);

    // Next frame clears err; then an empty frame.
    run_frame(8, 4, 0, 1'b0, -1);
    chk("err_cleared", err, 0);
    run_frame(0, 4, 0, 1'b1, -1);

    // Reset during block 2 of 4.
    for (int i = 0; i < 64; i++) bits_a[i] = 1'($urandom);
    vo_cyc.delete();
    push_model(40, 10, 1'b1, nb, no);
    load_frame(40, 10, 0, 1'b1, fd);
    got = 0;
    for (int k = 0; k < 500 && !got; k++) begin
      if (vo_cyc.size() >= 15) got = 1;
      else tick();
    end
    chk("rst_reached_blk2", got, 1);
    reset = 1'b1;
    tick();
    chk("midreset_outputs", {data_out, valid_out, sob, eob, n_blocks, busy, done, err}, 0);
    exp_q.delete();
    reset = 1'b0;
    tick();
    run_frame(20, 10, 0, 1'b1, -1);

    // Overflow on the 16-bit instance; the large instance sees a normal 17-bit frame.
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    small_q.delete();
    small_done = 0;
    for (int i = 0; i < 64; i++) bits_a[i] = 1'($urandom);
    run_frame(17, 4, 0, 1'b1, -1);
    chk("ovf_err", err_s, 1);
    chk("ovf_n_blocks", n_blocks_s, 4);
    chk("ovf_count", small_q.size(), 16);
    chk("ovf_done", small_done, 1);
    mism = 0;
    for (int i = 0; i < 16 && i < small_q.size(); i++) if (small_q[i] !== bits_a[i]) mism++;
    chk("ovf_data_mismatches", mism, 0);

    // Random frames.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 64; i++) bits_a[i] = 1'($urandom);
      n  = $urandom_range(1, 60);
      bs = $urandom_range(1, 31);
      gp = $urandom_range(0, 7);
      run_frame(n, bs, gp, 1'($urandom_range(0, 1)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
